gfx_host_if: RTL

- Host-bus front end of the graphics adapter; sits directly upstream of the screen RAM write port and the display controllers.
- Samples the asynchronous 6502-style bus (phi2, cs_n, rs, wren_n, data) in the fast pixel-fetch clock domain.
- Owns the 16-byte register file and auto-increments the screen write address.
- Buffers screen-byte writes in a small FIFO so RAM writes never collide with bus timing.

---
 rtl/gfx_pkg.sv | 27 ++
 rtl/gfx_wr_fifo.sv | 49 ++++
 rtl/gfx_host_if.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared constants and types for the graphics host-bus front end.
package gfx_pkg;

    // Register indices
    localparam logic [3:0] REG_MODE    = 4'd0;
    localparam logic [3:0] REG_DATA    = 4'd1;
    localparam logic [3:0] REG_CTRL    = 4'd2;
    localparam logic [3:0] REG_ADDR_LO = 4'd3;
    localparam logic [3:0] REG_ADDR_HI = 4'd4;
    localparam logic [3:0] REG_STATUS  = 4'd5;

    // Status register bit positions (count lives in bits [3:0])
    localparam int STAT_OVF   = 7;
    localparam int STAT_FULL  = 6;
    localparam int STAT_EMPTY = 5;

    // Control register bit positions
    localparam int CTRL_AUTOINC = 0;
    localparam int CTRL_IRQ_EN  = 1;

    // One buffered screen write
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } fifo_entry_t;

endpackage

// File: rtl/gfx_wr_fifo.sv
// Synchronous circular FIFO for screen writes. Caller gates push so it never
// overruns; a push and pop in the same cycle while full reuses the head slot.
module gfx_wr_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  fifo_entry_t entry_i,
    input  logic        pop_i,
    output fifo_entry_t head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [3:0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    cnt_q;

    // Storage: contents need no reset, pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= entry_i;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      cnt_q <= cnt_q + 4'd1;
            else if (!push_i && pop_i) cnt_q <= cnt_q - 4'd1;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 4'(DEPTH));
    assign empty_o = (cnt_q == 4'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/gfx_host_if.sv
// Host-bus front end: synchronises the 6502-style bus into clk, owns the
// 16-byte register file, auto-increments the screen address and buffers
// screen writes. Optional GFX_HOST_IRQ_EN adds a drain-complete irq_n.
module gfx_host_if
    import gfx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phi2,
    input  logic        cs_n,
    input  logic [3:0]  rs,
    input  logic        wren_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [1:0]  mode,
`ifdef GFX_HOST_IRQ_EN
    output logic        irq_n,
`endif
    output logic        scr_wr_valid,
    input  logic        scr_wr_ready,
    output logic [15:0] scr_wr_addr,
    output logic [7:0]  scr_wr_data
);

    logic [SYNC_STAGES-1:0]      phi2_sq, cs_sq, wr_sq;
    logic [SYNC_STAGES-1:0][3:0] rs_sq;
    logic                        phi2_prev_q;
    logic [7:0]                  data_q;
    logic [7:0]                  reg_q [16];
    logic                        ovf_q;

    logic        phi2_s, cs_s, wr_s;
    logic [3:0]  rs_s;
    logic        bus_end, wr_commit, rd_commit;
    logic        push_req, push_acc, pop;
    logic        fifo_full, fifo_empty;
    logic [3:0]  fifo_cnt;
    fifo_entry_t fifo_head, fifo_in;
    logic [15:0] addr_d;
    logic [7:0]  status;

    // Bus input synchronisers plus phi2 history for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_sq     <= '0;
            cs_sq       <= '0;
            wr_sq       <= '0;
            rs_sq       <= '0;
            phi2_prev_q <= 1'b0;
        end else begin
            phi2_sq     <= {phi2_sq[SYNC_STAGES-2:0], phi2};
            cs_sq       <= {cs_sq[SYNC_STAGES-2:0], cs_n};
            wr_sq       <= {wr_sq[SYNC_STAGES-2:0], wren_n};
            rs_sq       <= {rs_sq[SYNC_STAGES-2:0], rs};
            phi2_prev_q <= phi2_s;
        end
    end

    assign phi2_s = phi2_sq[SYNC_STAGES-1];
    assign cs_s   = cs_sq[SYNC_STAGES-1];
    assign wr_s   = wr_sq[SYNC_STAGES-1];
    assign rs_s   = rs_sq[SYNC_STAGES-1];

    // A bus cycle ends on the synced phi2 falling edge while selected
    assign bus_end   = phi2_prev_q & ~phi2_s & ~cs_s;
    assign wr_commit = bus_end & ~wr_s;
    assign rd_commit = bus_end & wr_s;

    // Push is accepted when there is room, or the head leaves this cycle
    assign pop      = ~fifo_empty & scr_wr_ready;
    assign push_req = wr_commit & (rs_s == REG_DATA);
    assign push_acc = push_req & (~fifo_full | pop);
    assign fifo_in  = '{addr: {reg_q[REG_ADDR_HI], reg_q[REG_ADDR_LO]}, data: data_q};
    assign addr_d   = {reg_q[REG_ADDR_HI], reg_q[REG_ADDR_LO]} + 16'd1;

    // Data latch, register file, overflow flag and address auto-increment
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < 16; i++) reg_q[i] <= '0;
        end else begin
            if (phi2_s) data_q <= data_in;
            if (wr_commit) begin
                case (rs_s)
                    REG_DATA:   ;
                    REG_STATUS: ovf_q <= 1'b0;
                    default:    reg_q[rs_s] <= data_q;
                endcase
            end
            if (push_req && !push_acc) ovf_q <= 1'b1;
            if (push_acc) begin
                reg_q[REG_DATA] <= data_q;
                if (reg_q[REG_CTRL][CTRL_AUTOINC]) begin
                    reg_q[REG_ADDR_LO] <= addr_d[7:0];
                    reg_q[REG_ADDR_HI] <= addr_d[15:8];
                end
            end
        end
    end

    gfx_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_acc),
        .entry_i (fifo_in),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Read mux: status is assembled live, everything else comes from the file
    always_comb begin
        status             = '0;
        status[STAT_OVF]   = ovf_q;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[3:0]        = fifo_cnt;
        data_out           = (rs_s == REG_STATUS) ? status : reg_q[rs_s];
    end

    assign data_oe      = phi2 & ~cs_n & wren_n;
    assign mode         = reg_q[REG_MODE][1:0];
    assign scr_wr_valid = ~fifo_empty;
    assign scr_wr_addr  = fifo_empty ? 16'h0 : fifo_head.addr;
    assign scr_wr_data  = fifo_empty ? 8'h0  : fifo_head.data;

`ifdef GFX_HOST_IRQ_EN
    logic drain_q, irq_n_q;

    // Flag the pop that empties the FIFO; irq asserts the cycle after empty
    // shows, and a reg5 read acknowledges. A new drain beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_q <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            drain_q <= pop & (fifo_cnt == 4'd1) & ~push_acc;
            if (rd_commit && rs_s == REG_STATUS) irq_n_q <= 1'b1;
            if (drain_q && reg_q[REG_CTRL][CTRL_IRQ_EN]) irq_n_q <= 1'b0;
        end
    end

    assign irq_n = irq_n_q;
`endif

endmodule
